// File: rtl/cnn_layer_accel_macc_ctrl.sv
// MACC sequencing controller: counts operand beats per output and drives the
// accumulating DSP's accum/accum_rst through a latency-matched marker pipeline.
module cnn_layer_accel_macc_ctrl #(
   parameter int C_PIPE_LAT  = 3,
   parameter int C_CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [C_CNT_WIDTH-1:0] cfg_accum_len,
   input  logic [C_CNT_WIDTH-1:0] cfg_num_outputs,
   input  logic                   op_valid,
   output logic                   op_ready,
   output logic                   accum_rst,
   output logic                   accum,
   output logic                   result_valid,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // One marker per cycle travels alongside the operand to the accumulating DSP.
   typedef struct packed {
      logic v;
      logic first;
      logic last;
   } marker_t;

   localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

   state_t                 state;
   logic [C_CNT_WIDTH-1:0] len_q;
   logic [C_CNT_WIDTH-1:0] num_q;
   logic [C_CNT_WIDTH-1:0] beat_cnt;
   logic [C_CNT_WIDTH-1:0] out_cnt;
   marker_t                pipe [C_PIPE_LAT];
   marker_t                tap;
   logic                   result_q;
   logic                   accept;
   logic                   beat_last;
   logic                   out_last;
   logic                   pipe_busy;

   assign accept    = op_valid & op_ready;
   assign beat_last = (beat_cnt == len_q - CNT_ONE);
   assign out_last  = (out_cnt == num_q - CNT_ONE);
   assign tap       = pipe[C_PIPE_LAT-1];

   // NOTE: the default before the loop keeps this purely combinational (no latch).
   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < C_PIPE_LAT; i++) pipe_busy = pipe_busy | pipe[i].v;
   end

   assign op_ready     = (state == RUN);
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign accum_rst    = tap.v & tap.first;
   assign accum        = tap.v & ~tap.first;
   assign result_valid = result_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         num_q    <= '0;
         beat_cnt <= '0;
         out_cnt  <= '0;
         result_q <= 1'b0;
         // NOTE: the marker pipeline is reset, unlike a datapath store, so no stale
         //       accum or result_valid can emerge after a reset.
         for (int i = 0; i < C_PIPE_LAT; i++) pipe[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage shift its old value.
         pipe[0] <= '{v: accept, first: (beat_cnt == '0), last: beat_last};
         for (int i = 1; i < C_PIPE_LAT; i++) pipe[i] <= pipe[i-1];
         result_q <= tap.v & tap.last;

         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= cfg_accum_len;
                  num_q    <= cfg_num_outputs;
                  beat_cnt <= '0;
                  out_cnt  <= '0;
                  state    <= ((cfg_accum_len != '0) && (cfg_num_outputs != '0)) ? RUN : DONE;
               end
            end
            RUN: begin
               if (accept) begin
                  if (beat_last) begin
                     beat_cnt <= '0;
                     out_cnt  <= out_cnt + CNT_ONE;
                     if (out_last) state <= DRAIN;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_ONE;
                  end
               end
            end
            // Earlier outputs may still be finishing; only the sum that leaves an
            // empty pipeline behind is the final one.
            DRAIN: begin
               if (result_q && !pipe_busy) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_macc_ctrl.sv
// Bench for cnn_layer_accel_macc_ctrl: event-scheduling reference model compared
// every cycle, plus hand-computed pulse maps for the directed jobs.
module tb_cnn_layer_accel_macc_ctrl;

   localparam int L    = 3;
   localparam int W    = 8;
   localparam int RING = 1024;
   localparam int SPAN = 24;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         op_valid = 1'b0;
   logic [W-1:0] cfg_accum_len = '0;
   logic [W-1:0] cfg_num_outputs = '0;
   logic         op_ready, accum_rst, accum, result_valid, busy, done;

   cnn_layer_accel_macc_ctrl #(.C_PIPE_LAT(L), .C_CNT_WIDTH(W)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cfg_accum_len   (cfg_accum_len),
      .cfg_num_outputs (cfg_num_outputs),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .accum_rst       (accum_rst),
      .accum           (accum),
      .result_valid    (result_valid),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got 'h%0h, expected 'h%0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: each accept schedules its DSP-side events at fixed offsets.
   bit       e_rst [RING];
   bit       e_acc [RING];
   bit       e_rv  [RING];
   bit       e_done[RING];
   bit       m_busy = 1'b0;
   bit       m_run  = 1'b0;
   int       m_len, m_num, m_beat, m_out;
   logic [4:0] lg [RING];

   always @(negedge clk) begin
      int  k;
      bit  was_done;
      k = cyc % RING;
      lg[k] = {op_ready, done, result_valid, accum, accum_rst};
      if (rst) begin
         check("reset_outputs", 32'({op_ready, accum, accum_rst, result_valid, busy, done}), 32'd0);
         m_busy = 1'b0;
         m_run  = 1'b0;
         for (int i = 0; i < RING; i++) begin
            e_rst[i] = 1'b0; e_acc[i] = 1'b0; e_rv[i] = 1'b0; e_done[i] = 1'b0;
         end
      end else begin
         check("op_ready",     32'(op_ready),     32'(m_run));
         check("busy",         32'(busy),         32'(m_busy));
         check("done",         32'(done),         32'(e_done[k]));
         check("accum_rst",    32'(accum_rst),    32'(e_rst[k]));
         check("accum",        32'(accum),        32'(e_acc[k]));
         check("result_valid", 32'(result_valid), 32'(e_rv[k]));
         check("accum_excl",   32'(accum & accum_rst), 32'd0);
         was_done  = e_done[k];
         e_rst[k]  = 1'b0; e_acc[k] = 1'b0; e_rv[k] = 1'b0; e_done[k] = 1'b0;
         if (!m_busy && start) begin
            m_len  = int'(cfg_accum_len);
            m_num  = int'(cfg_num_outputs);
            m_beat = 0;
            m_out  = 0;
            m_busy = 1'b1;
            if (m_len != 0 && m_num != 0) m_run = 1'b1;
            else e_done[(cyc + 1) % RING] = 1'b1;
         end else if (m_run && op_valid) begin
            if (m_beat == 0) e_rst[(cyc + L) % RING] = 1'b1;
            else             e_acc[(cyc + L) % RING] = 1'b1;
            if (m_beat == m_len - 1) begin
               e_rv[(cyc + L + 1) % RING] = 1'b1;
               m_beat = 0;
               m_out++;
               if (m_out == m_num) begin
                  m_run = 1'b0;
                  e_done[(cyc + L + 2) % RING] = 1'b1;
               end
            end else begin
               m_beat++;
            end
         end
         if (was_done) m_busy = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int len, input int num, output int c0);
      c0              = cyc;
      start           = 1'b1;
      cfg_accum_len   = W'(len);
      cfg_num_outputs = W'(num);
      tick();
      start           = 1'b0;
      cfg_accum_len   = W'($urandom);
      cfg_num_outputs = W'($urandom);
   endtask

   // sel: 0 accum_rst, 1 accum, 2 result_valid, 3 done, 4 op_ready; bit i = cycle c0+i
   task automatic check_mask(input string name, input int sel, input int c0, input logic [31:0] exp);
      logic [31:0] act;
      act = '0;
      for (int i = 0; i < SPAN; i++) act[i] = lg[(c0 + i) % RING][sel];
      check(name, act, exp);
   endtask

   task automatic run_until_idle(input int budget, input int valid_pct, input bit noise);
      int n;
      n = 0;
      while (m_busy && n < budget) begin
         op_valid = ($urandom_range(99) < valid_pct);
         if (noise && $urandom_range(9) == 0) begin
            start           = 1'b1;
            cfg_accum_len   = W'($urandom);
            cfg_num_outputs = W'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
         n++;
      end
      start    = 1'b0;
      op_valid = 1'b0;
      check("job_within_budget", 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      int c0, c1, len, num;
      #1 rst = 1'b1;
      #1 check("reset_immediate", 32'({op_ready, accum, accum_rst, result_valid, busy, done}), 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // len=4, outputs=2, op_valid held high
      op_valid = 1'b1;
      start_job(4, 2, c0);
      repeat (SPAN - 1) tick();
      check_mask("j1_accum_rst", 0, c0, 32'h110);
      check_mask("j1_accum",     1, c0, 32'hEE0);
      check_mask("j1_result",    2, c0, 32'h1100);
      check_mask("j1_done",      3, c0, 32'h2000);
      check_mask("j1_ready",     4, c0, 32'h1FE);

      // len=3, outputs=1, two-cycle gap after the first beat
      start_job(3, 1, c0);
      tick();
      op_valid = 1'b0;
      tick();
      tick();
      op_valid = 1'b1;
      repeat (SPAN - 4) tick();
      check_mask("j2_accum_rst", 0, c0, 32'h10);
      check_mask("j2_accum",     1, c0, 32'h180);
      check_mask("j2_result",    2, c0, 32'h200);
      check_mask("j2_done",      3, c0, 32'h400);
      check_mask("j2_ready",     4, c0, 32'h3E);

      // len=1, outputs=3
      start_job(1, 3, c0);
      repeat (SPAN - 1) tick();
      check_mask("j3_accum_rst", 0, c0, 32'h70);
      check_mask("j3_accum",     1, c0, 32'h0);
      check_mask("j3_result",    2, c0, 32'hE0);
      check_mask("j3_done",      3, c0, 32'h100);

      // zero outputs: straight to done
      start_job(5, 0, c0);
      repeat (SPAN - 1) tick();
      check_mask("j4_done",      3, c0, 32'h2);
      check_mask("j4_ready",     4, c0, 32'h0);
      check_mask("j4_accum_rst", 0, c0, 32'h0);
      check_mask("j4_accum",     1, c0, 32'h0);
      check_mask("j4_result",    2, c0, 32'h0);

      // start with new cfg mid-RUN is ignored
      start_job(4, 2, c0);
      tick();
      tick();
      start           = 1'b1;
      cfg_accum_len   = W'(2);
      cfg_num_outputs = W'(1);
      tick();
      start = 1'b0;
      repeat (SPAN - 4) tick();
      check_mask("j5_accum_rst", 0, c0, 32'h110);
      check_mask("j5_result",    2, c0, 32'h1100);
      check_mask("j5_done",      3, c0, 32'h2000);

      // reset two cycles after the fifth accept
      start_job(4, 2, c0);
      repeat (6) tick();
      check("accum_before_reset", 32'(accum), 32'd1);
      rst = 1'b1;
      #1 check("reset_mid_run", 32'({op_ready, accum, accum_rst, result_valid, busy, done}), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      repeat (SPAN - 2) tick();
      check_mask("after_reset_result", 2, c0 + 7, 32'h0);
      check_mask("after_reset_done",   3, c0 + 7, 32'h0);
      start_job(2, 2, c1);
      repeat (SPAN - 1) tick();
      check_mask("j6_accum_rst", 0, c1, 32'h50);
      check_mask("j6_accum",     1, c1, 32'hA0);
      check_mask("j6_result",    2, c1, 32'h140);
      check_mask("j6_done",      3, c1, 32'h200);

      // randomized jobs with stalls and stray start pulses
      op_valid = 1'b0;
      for (int j = 0; j < 12; j++) begin
         len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 6));
         num = int'($urandom_range(0, 3));
         op_valid = ($urandom_range(1) == 1);
         start_job(len, num, c0);
         run_until_idle(400, 70, 1'b1);
      end

      // maximum cfg values
      start_job(255, 2, c0);
      run_until_idle(800, 90, 1'b0);
      start_job(1, 255, c0);
      run_until_idle(600, 100, 1'b1);

      repeat (4) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
